button_debounce: RTL and testbench
==================================

Name: button_debounce

Overview:
- Input-conditioning stage directly upstream of the buttons PIO. Drives the PIO's 4-bit in_port.
- Takes the raw, asynchronous, bouncing push-button pins and synchronises each to clk.
- Debounces each channel independently with its own stability counter.
- Outputs clean active-high "pressed" levels plus one-cycle press and release pulses for fabric logic and interrupt sources.

Parameters:
- WIDTH, 4, number of button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles required to accept a new level (20 ms at 50 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 20, width of each per-channel counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed (board KEYs); 0 = raw pin reads 1 when pressed.

Ports:
- clk  in  1  system clock, same domain as the buttons PIO.
- reset_n  in  1  asynchronous active-low reset.
- key_raw  in  WIDTH  raw button pins, asynchronous to clk, may bounce.
- key_pressed  out  WIDTH  debounced level, 1 = pressed; connects to PIO in_port.
- press_pulse  out  WIDTH  1-cycle pulse when a channel's key_pressed goes 0->1.
- release_pulse  out  WIDTH  1-cycle pulse when a channel's key_pressed goes 1->0.

Behaviour:

Clock and reset:
- One clock, clk. Reset is asynchronous, active-low, named reset_n.
- All flops reset asynchronously on reset_n low.

Reset values:
- Synchroniser stages = released pin level (all 1s if ACTIVE_LOW=1, else all 0s).
- key_pressed = 0, press_pulse = 0, release_pulse = 0, all counters = 0.

Synchronisation:
- Per bit: two-flop synchroniser (sync1 -> sync2).
- Polarity normalised after sync2: p = sync2 XOR ACTIVE_LOW, so p = 1 means pressed.

Per-channel debounce (state = stable bit key_pressed[i] plus counter cnt[i]):
- IDLE (p == key_pressed[i]): cnt <= 0.
- COUNTING (p != key_pressed[i]) and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
- ACCEPT (p != key_pressed[i]) and cnt == DEBOUNCE_CYCLES-1: key_pressed[i] <= p, cnt <= 0, and the matching pulse asserts on that same edge.
- Any single cycle with p == key_pressed[i] during counting returns the channel to 0. Bounces therefore restart the count; partial counts never accumulate.

Pulses:
- Registered, asserted for exactly one cycle, coincident with the key_pressed transition.
- press_pulse[i] and release_pulse[i] are never high together.

Latency:
- A clean raw level change held steady updates key_pressed exactly 2 + DEBOUNCE_CYCLES clk edges after the first edge that samples the new raw level.
- Release uses the same latency as press (symmetric).

Channel independence:
- Simultaneous events on different channels are handled independently, so multiple pulse bits may be high in the same cycle.

Counter behaviour:
- Counter never exceeds DEBOUNCE_CYCLES-1, so no wrap-around is possible.
- No saturation logic is needed beyond the ACCEPT reset to 0.

Reset mid-operation:
- Reset during counting discards the count, forces released state, and issues no pulse.
- A key held down through reset deassertion is reported as a press 2 + DEBOUNCE_CYCLES cycles after reset release.

Output driving:
- Outputs are driven directly from flops, with no combinational path from key_raw.

Test Plan (DEBOUNCE_CYCLES=8, CNT_W=4, WIDTH=4, ACTIVE_LOW=1):
1. Reset with key_raw=4'hF, release reset -> key_pressed=0, no pulses for 20 cycles.
2. Drive key_raw[0]=0 and hold -> key_pressed[0] rises exactly 10 cycles later. press_pulse=4'h1 for one cycle at that edge. Other bits stay 0.
3. Bounce on key_raw[1]: low 7 cycles, high 1, low 7, high -> key_pressed stays 0 and no pulses. Then hold low -> press accepted 10 cycles after the final falling edge.
4. With key_pressed[2]=1, raise key_raw[2] -> key_pressed[2] falls 10 cycles later. release_pulse=4'h4 for one cycle. press_pulse stays 0.
5. Drive key_raw 4'hF->4'h0 in one cycle -> all four key_pressed bits rise on the same edge, press_pulse=4'hF for one cycle.
6. Hold key_raw[3]=0, assert reset_n low at count 5 for 2 cycles, then release -> no pulse during reset. press_pulse[3] fires 10 cycles after reset release.

Source files
------------

// File: rtl/button_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | button_debounce: synchronise, debounce and edge-detect buttons    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module button_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_pressed,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  localparam logic             c_POL      = (ACTIVE_LOW != 0);
  localparam logic [WIDTH-1:0] c_RELEASED = {WIDTH{c_POL}};
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] w_p;

  // Synchronisers rest at the released pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= c_RELEASED;
      r_sync2 <= c_RELEASED;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_p = r_sync2 ^ c_RELEASED;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      logic [CNT_W-1:0] r_cnt;
      logic             r_level;
      logic             r_press;
      logic             r_release;
      logic             w_diff;
      logic             w_accept;

      assign w_diff   = w_p[i] ^ r_level;
      assign w_accept = w_diff && (r_cnt == c_CNT_LAST);

      // Any cycle agreeing with the stable level clears the count, so bounces restart it.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt     <= '0;
          r_level   <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_press   <= w_accept & w_p[i];
          r_release <= w_accept & ~w_p[i];
          if (w_accept) begin
            r_level <= w_p[i];
            r_cnt   <= '0;
          end else if (w_diff) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
          end
        end
      end

      assign key_pressed[i]   = r_level;
      assign press_pulse[i]   = r_press;
      assign release_pulse[i] = r_release;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_button_debounce: scoreboard bench for button_debounce          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_button_debounce;
  localparam int WIDTH = 4;
  localparam int DB    = 8;
  localparam int LAT   = DB + 2;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] key_raw;
  logic [WIDTH-1:0] key_pressed;
  logic [WIDTH-1:0] press_pulse;
  logic [WIDTH-1:0] release_pulse;

  button_debounce #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (4),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_raw      (key_raw),
    .key_pressed  (key_pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] rel;
    logic [WIDTH-1:0] level;
  } ev_t;

  ev_t              sb[$];
  int               cyc;
  int               n_cmp;
  int               n_err;
  logic [WIDTH-1:0] exp_level;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops an event when due, flags spurious or missing pulses, tracks the level.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_level = '0;
    end else begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        n_cmp++; n_err++;
        $display("FAIL missed_event: expected pulse at cycle %0d, now %0d", sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        ev_t e;
        e = sb.pop_front();
        n_cmp++;
        if (press_pulse !== e.press || release_pulse !== e.rel || key_pressed !== e.level) begin
          n_err++;
          $display("FAIL event@%0d: got press=%h rel=%h lvl=%h, want press=%h rel=%h lvl=%h",
                   cyc, press_pulse, release_pulse, key_pressed, e.press, e.rel, e.level);
        end
        exp_level = e.level;
      end else if (press_pulse !== '0 || release_pulse !== '0) begin
        n_cmp++; n_err++;
        $display("FAIL spurious_pulse@%0d: press=%h rel=%h, want 0/0", cyc, press_pulse, release_pulse);
      end
      n_cmp++;
      if (key_pressed !== exp_level) begin
        n_err++;
        $display("FAIL level@%0d: got %h want %h", cyc, key_pressed, exp_level);
      end
    end
  end

  task automatic expect_ev(input int at, input logic [WIDTH-1:0] pr,
                           input logic [WIDTH-1:0] rl, input logic [WIDTH-1:0] lv);
    ev_t e;
    e.cyc = at; e.press = pr; e.rel = rl; e.level = lv;
    sb.push_back(e);
  endtask

  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if (key_pressed !== '0 || press_pulse !== '0 || release_pulse !== '0) begin
      n_err++;
      $display("FAIL %s: got lvl=%h press=%h rel=%h, want all 0", name,
               key_pressed, press_pulse, release_pulse);
    end
  endtask

  // Change raw pins on a negedge and schedule the debounced event LAT edges later.
  task automatic drive(input logic [WIDTH-1:0] raw, input logic [WIDTH-1:0] pr,
                       input logic [WIDTH-1:0] rl, input logic [WIDTH-1:0] lv);
    key_raw = raw;
    expect_ev(cyc + LAT, pr, rl, lv);
    repeat (LAT + 4) @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; exp_level = '0;
    key_raw = 4'hF;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    reset_n = 1'b1;

    // 1: idle after reset, monitor flags any pulse
    repeat (20) @(negedge clk);

    // 2: press key 0
    drive(4'hE, 4'h1, 4'h0, 4'h1);

    // 3: bounce on key 1 never reaches the threshold, then a held press
    key_raw = 4'hC; repeat (7) @(negedge clk);
    key_raw = 4'hE; repeat (1) @(negedge clk);
    key_raw = 4'hC; repeat (7) @(negedge clk);
    key_raw = 4'hE; repeat (1) @(negedge clk);
    drive(4'hC, 4'h2, 4'h0, 4'h3);

    // 4: press then release key 2
    drive(4'h8, 4'h4, 4'h0, 4'h7);
    drive(4'hC, 4'h0, 4'h4, 4'h3);

    // 5: release all, then press all at once
    drive(4'hF, 4'h0, 4'h3, 4'h0);
    drive(4'h0, 4'hF, 4'h0, 4'hF);
    drive(4'hF, 4'h0, 4'hF, 4'h0);

    // 6: reset while key 3 is counting
    key_raw = 4'h7;
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_mid_count_a");
    @(negedge clk);
    check_reset_outputs("reset_mid_count_b");
    reset_n = 1'b1;
    expect_ev(cyc + LAT, 4'h8, 4'h0, 4'h8);
    repeat (LAT + 6) @(negedge clk);

    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d events left, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
